// File: rtl/nv_nvdla_cacc_pkg.sv
// Shared CACC definitions: requester identifiers and assembly-buffer read latency.
package nv_nvdla_cacc_pkg;

  typedef enum logic {
    ACC = 1'b0,
    DLV = 1'b1
  } req_id_e;

  localparam int ABUF_RD_LAT = 2;

  function automatic req_id_e other_id(input req_id_e id);
    return (id == ACC) ? DLV : ACC;
  endfunction

endpackage

// File: rtl/nv_nvdla_cacc_abuf_rdtag.sv
// Delay pipe carrying {valid, requester id} alongside an assembly-buffer read.
module nv_nvdla_cacc_abuf_rdtag
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int STAGES = ABUF_RD_LAT
) (
  input  logic    nvdla_core_clk,
  input  logic    nvdla_core_rstn,
  input  logic    in_vld,
  input  req_id_e in_id,
  output logic    out_vld,
  output req_id_e out_id,
  output logic    busy
);

  logic [STAGES-1:0] vld_p;
  req_id_e           id_p [STAGES];

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      vld_p <= '0;
    end else begin
      vld_p[0] <= in_vld;
      for (int i = 1; i < STAGES; i++) begin
        vld_p[i] <= vld_p[i-1];
      end
    end
  end

  // Ids are only meaningful under their valid bit, so they are left unreset.
  always_ff @(posedge nvdla_core_clk) begin
    id_p[0] <= in_id;
    for (int i = 1; i < STAGES; i++) begin
      id_p[i] <= id_p[i-1];
    end
  end

  assign out_vld = vld_p[STAGES-1];
  assign out_id  = id_p[STAGES-1];
  assign busy    = |vld_p;

endmodule

// File: rtl/nv_nvdla_cacc_abuf_arb.sv
// Assembly-buffer read arbiter (accumulate vs delivery) with write pass-through.
// Define NVDLA_CACC_ABUF_ARB_RR_EN for round-robin; default is fixed priority acc > dlv.
module nv_nvdla_cacc_abuf_arb
  import nv_nvdla_cacc_pkg::*;
#(
  parameter int AW = 6,
  parameter int DW = 512
) (
  input  logic          nvdla_core_clk,
  input  logic          nvdla_core_rstn,
  input  logic          acc_rd_req_valid,
  output logic          acc_rd_req_ready,
  input  logic [AW-1:0] acc_rd_req_addr,
  input  logic          dlv_rd_req_valid,
  output logic          dlv_rd_req_ready,
  input  logic [AW-1:0] dlv_rd_req_addr,
  input  logic          acc_wr_en,
  input  logic [AW-1:0] acc_wr_addr,
  input  logic [DW-1:0] acc_wr_data,
  output logic          abuf_rd_en,
  output logic [AW-1:0] abuf_rd_addr,
  output logic          abuf_wr_en,
  output logic [AW-1:0] abuf_wr_addr,
  output logic [DW-1:0] abuf_wr_data,
  input  logic [DW-1:0] abuf_rd_data,
  output logic          acc_rd_rsp_valid,
  output logic          dlv_rd_rsp_valid,
  output logic [DW-1:0] rd_rsp_data,
  output logic          rd_busy
);

  logic    acc_hz;
  logic    dlv_hz;
  logic    acc_gnt;
  logic    dlv_gnt;
  req_id_e gnt_id;
  logic    tag_vld;
  req_id_e tag_id;

  assign abuf_wr_en   = acc_wr_en;
  assign abuf_wr_addr = acc_wr_addr;
  assign abuf_wr_data = acc_wr_data;

  // A read of the address being written this cycle would return stale data.
  assign acc_hz = acc_wr_en && (acc_wr_addr == acc_rd_req_addr);
  assign dlv_hz = acc_wr_en && (acc_wr_addr == dlv_rd_req_addr);

`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
  // prio_q names the requester that wins the next conflict.
  req_id_e prio_q;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      prio_q <= ACC;
    end else if (acc_gnt || dlv_gnt) begin
      prio_q <= other_id(gnt_id);
    end
  end

  assign acc_rd_req_ready = nvdla_core_rstn && !acc_hz &&
                            !(dlv_rd_req_valid && !dlv_hz && (prio_q == DLV));
  assign dlv_rd_req_ready = nvdla_core_rstn && !dlv_hz &&
                            !(acc_rd_req_valid && !acc_hz && (prio_q == ACC));
`else
  assign acc_rd_req_ready = nvdla_core_rstn && !acc_hz;
  assign dlv_rd_req_ready = nvdla_core_rstn && !dlv_hz &&
                            !(acc_rd_req_valid && !acc_hz);
`endif

  assign acc_gnt = acc_rd_req_valid && acc_rd_req_ready;
  assign dlv_gnt = dlv_rd_req_valid && dlv_rd_req_ready;
  assign gnt_id  = dlv_gnt ? DLV : ACC;

  assign abuf_rd_en   = acc_gnt || dlv_gnt;
  assign abuf_rd_addr = acc_gnt ? acc_rd_req_addr :
                        dlv_gnt ? dlv_rd_req_addr : '0;

  nv_nvdla_cacc_abuf_rdtag #(
    .STAGES(ABUF_RD_LAT)
  ) u_rdtag (
    .nvdla_core_clk (nvdla_core_clk),
    .nvdla_core_rstn(nvdla_core_rstn),
    .in_vld         (abuf_rd_en),
    .in_id          (gnt_id),
    .out_vld        (tag_vld),
    .out_id         (tag_id),
    .busy           (rd_busy)
  );

  assign acc_rd_rsp_valid = tag_vld && (tag_id == ACC);
  assign dlv_rd_rsp_valid = tag_vld && (tag_id == DLV);
  assign rd_rsp_data      = abuf_rd_data;

endmodule

// File: tb/tb_nv_nvdla_cacc_abuf_arb.sv
// Self-checking bench for nv_nvdla_cacc_abuf_arb with a buffer model and response scoreboard.
module tb_nv_nvdla_cacc_abuf_arb;
  localparam int AW = 6;
  localparam int DW = 64;

  logic          clk;
  logic          rst_n;
  logic          acc_v, dlv_v, acc_rdy, dlv_rdy;
  logic [AW-1:0] acc_a, dlv_a;
  logic          wr_en;
  logic [AW-1:0] wr_a;
  logic [DW-1:0] wr_d;
  logic          abuf_rd_en, abuf_wr_en;
  logic [AW-1:0] abuf_rd_addr, abuf_wr_addr;
  logic [DW-1:0] abuf_wr_data, abuf_rd_data, rd_rsp_data;
  logic          acc_rsp, dlv_rsp, rd_busy;

  nv_nvdla_cacc_abuf_arb #(.AW(AW), .DW(DW)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rst_n),
    .acc_rd_req_valid(acc_v),
    .acc_rd_req_ready(acc_rdy),
    .acc_rd_req_addr (acc_a),
    .dlv_rd_req_valid(dlv_v),
    .dlv_rd_req_ready(dlv_rdy),
    .dlv_rd_req_addr (dlv_a),
    .acc_wr_en       (wr_en),
    .acc_wr_addr     (wr_a),
    .acc_wr_data     (wr_d),
    .abuf_rd_en      (abuf_rd_en),
    .abuf_rd_addr    (abuf_rd_addr),
    .abuf_wr_en      (abuf_wr_en),
    .abuf_wr_addr    (abuf_wr_addr),
    .abuf_wr_data    (abuf_wr_data),
    .abuf_rd_data    (abuf_rd_data),
    .acc_rd_rsp_valid(acc_rsp),
    .dlv_rd_rsp_valid(dlv_rsp),
    .rd_rsp_data     (rd_rsp_data),
    .rd_busy         (rd_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(input int a);
    return {32'hC0DE0000 | 32'(a), 32'h5A5A0000 ^ 32'(a * 7 + 1)};
  endfunction

  // Buffer model: 2-cycle read latency, fed by the DUT's buffer ports.
  logic [DW-1:0] mem [64];
  logic [63:0]   written;
  logic          mem_clr;
  logic [DW-1:0] rd_d1, rd_d2;
  always @(posedge clk) begin
    if (mem_clr) written <= '0;
    else if (abuf_wr_en) begin
      mem[abuf_wr_addr]     <= abuf_wr_data;
      written[abuf_wr_addr] <= 1'b1;
    end
    if (abuf_rd_en) rd_d1 <= written[abuf_rd_addr] ? mem[abuf_rd_addr] : init_val(int'(abuf_rd_addr));
    rd_d2 <= rd_d1;
  end
  assign abuf_rd_data = rd_d2;

  typedef struct {
    int            due;
    logic          id;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t sbq[$];

  typedef struct packed {
    logic av; logic [AW-1:0] aa;
    logic dv; logic [AW-1:0] da;
    logic we; logic [AW-1:0] wa;
    logic ren; logic [AW-1:0] raddr; logic [1:0] gnt;
  } vec_t;
  vec_t vt [9];

  int n_chk, n_pass, cyc, rsp_cnt;
  logic [DW-1:0] exp_mem [64];
  logic [DW-1:0] last_acc_data, last_dlv_data;
  int            last_acc_cyc;
  logic [1:0]    dut_gnt;
  logic [AW-1:0] dut_addr;
  logic          m_ga, m_gd;
`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
  logic          m_prio;
`endif

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", nm, cyc, act, exp);
  endtask

  task automatic check();
    logic ahz, dhz, er_a, er_d, bexp;
    rsp_t e;
    dut_addr = abuf_rd_addr;
    dut_gnt  = abuf_rd_en ? ((acc_v && acc_rdy) ? 2'd0 : 2'd1) : 2'd2;
    if (!rst_n) begin
      sbq.delete();
`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
      m_prio = 1'b0;
`endif
      m_ga = 1'b0; m_gd = 1'b0;
      chk("rst_rd_en", DW'(abuf_rd_en), '0);
      chk("rst_acc_rsp", DW'(acc_rsp), '0);
      chk("rst_dlv_rsp", DW'(dlv_rsp), '0);
      chk("rst_busy", DW'(rd_busy), '0);
      return;
    end
    ahz = wr_en && (wr_a == acc_a);
    dhz = wr_en && (wr_a == dlv_a);
`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
    er_a = !ahz && !(dlv_v && !dhz && m_prio);
    er_d = !dhz && !(acc_v && !ahz && !m_prio);
`else
    er_a = !ahz;
    er_d = !dhz && !(acc_v && !ahz);
`endif
    m_ga = acc_v && er_a;
    m_gd = dlv_v && er_d;
    chk("acc_ready", DW'(acc_rdy), DW'(er_a));
    chk("dlv_ready", DW'(dlv_rdy), DW'(er_d));
    chk("rd_en", DW'(abuf_rd_en), DW'(m_ga || m_gd));
    chk("rd_addr", DW'(abuf_rd_addr), m_ga ? DW'(acc_a) : m_gd ? DW'(dlv_a) : '0);
    chk("wr_en", DW'(abuf_wr_en), DW'(wr_en));
    chk("wr_addr", DW'(abuf_wr_addr), DW'(wr_a));
    chk("wr_data", abuf_wr_data, wr_d);
    bexp = 1'b0;
    foreach (sbq[i]) if (sbq[i].due == cyc || sbq[i].due == cyc + 1) bexp = 1'b1;
    chk("rd_busy", DW'(rd_busy), DW'(bexp));
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      e = sbq.pop_front();
      chk("acc_rsp", DW'(acc_rsp), DW'(!e.id));
      chk("dlv_rsp", DW'(dlv_rsp), DW'(e.id));
      chk("rsp_data", rd_rsp_data, e.data);
      rsp_cnt++;
      if (e.id) last_dlv_data = rd_rsp_data;
      else begin last_acc_data = rd_rsp_data; last_acc_cyc = cyc; end
    end else begin
      chk("acc_rsp_idle", DW'(acc_rsp), '0);
      chk("dlv_rsp_idle", DW'(dlv_rsp), '0);
    end
    if (m_ga) sbq.push_back('{due: cyc + 2, id: 1'b0, data: exp_mem[acc_a]});
    if (m_gd) sbq.push_back('{due: cyc + 2, id: 1'b1, data: exp_mem[dlv_a]});
  endtask

  task automatic cycle();
    @(negedge clk);
    check();
    @(posedge clk);
`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
    if (rst_n && m_ga) m_prio = 1'b1;
    else if (rst_n && m_gd) m_prio = 1'b0;
`endif
    if (wr_en) exp_mem[wr_a] = wr_d;
    cyc++;
    #1;
  endtask

  task automatic idle(input int n);
    acc_v = 1'b0; dlv_v = 1'b0; wr_en = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    logic [1:0]    g [4];
    logic [1:0]    gexp [4];
    logic [DW-1:0] wdat;
    int            c0;
    n_chk = 0; n_pass = 0; cyc = 0; rsp_cnt = 0;
    last_acc_cyc = -1; last_acc_data = '0; last_dlv_data = '0;
    acc_a = '0; dlv_a = '0; wr_a = '0; wr_d = '0;
    for (int i = 0; i < 64; i++) exp_mem[i] = init_val(i);
    vt[0] = '{1'b1, 6'd5,  1'b0, 6'd0,  1'b0, 6'd0,  1'b1, 6'd5,  2'd0};
    vt[1] = '{1'b0, 6'd0,  1'b1, 6'd9,  1'b0, 6'd0,  1'b1, 6'd9,  2'd1};
    vt[2] = '{1'b1, 6'd7,  1'b0, 6'd0,  1'b1, 6'd7,  1'b0, 6'd0,  2'd2};
    vt[3] = '{1'b0, 6'd0,  1'b1, 6'd12, 1'b1, 6'd12, 1'b0, 6'd0,  2'd2};
    vt[4] = '{1'b1, 6'd3,  1'b1, 6'd4,  1'b1, 6'd3,  1'b1, 6'd4,  2'd1};
    vt[5] = '{1'b1, 6'd3,  1'b1, 6'd4,  1'b1, 6'd4,  1'b1, 6'd3,  2'd0};
    vt[6] = '{1'b1, 6'd8,  1'b1, 6'd8,  1'b1, 6'd8,  1'b0, 6'd0,  2'd2};
    vt[7] = '{1'b0, 6'd2,  1'b0, 6'd6,  1'b1, 6'd10, 1'b0, 6'd0,  2'd2};
    vt[8] = '{1'b1, 6'd63, 1'b0, 6'd0,  1'b1, 6'd0,  1'b1, 6'd63, 2'd0};

    rst_n = 1'b0; mem_clr = 1'b1;
    idle(2);
    rst_n = 1'b1; mem_clr = 1'b0;

    // Both requesters hold requests for 4 cycles, starting right after reset release.
    acc_v = 1'b1; acc_a = 6'd10; dlv_v = 1'b1; dlv_a = 6'd20;
    for (int i = 0; i < 4; i++) begin cycle(); g[i] = dut_gnt; end
`ifdef NVDLA_CACC_ABUF_ARB_RR_EN
    gexp = '{2'd0, 2'd1, 2'd0, 2'd1};
`else
    gexp = '{2'd0, 2'd0, 2'd0, 2'd0};
`endif
    for (int i = 0; i < 4; i++) chk($sformatf("conflict_gnt%0d", i), DW'(g[i]), DW'(gexp[i]));
    idle(3);

    // Single acc read of address 5, response two cycles later.
    acc_v = 1'b1; acc_a = 6'd5;
    c0 = cyc;
    cycle();
    chk("single_gnt", DW'(dut_gnt), 64'd0);
    chk("single_addr", DW'(dut_addr), 64'd5);
    idle(3);
    chk("single_rsp_cyc", DW'(last_acc_cyc), DW'(c0 + 2));
    chk("single_rsp_data", last_acc_data, init_val(5));

    // dlv read blocked by a same-address write, then reads the new data.
    wdat = 64'hFEED_0009_1234_5678;
    acc_v = 1'b1; acc_a = 6'd3; dlv_v = 1'b1; dlv_a = 6'd9;
    wr_en = 1'b1; wr_a = 6'd9; wr_d = wdat;
    cycle(); g[0] = dut_gnt;
    acc_v = 1'b0; wr_en = 1'b0;
    cycle(); g[1] = dut_gnt;
    idle(3);
    chk("hz_first_gnt", DW'(g[0]), 64'd0);
    chk("hz_second_gnt", DW'(g[1]), 64'd1);
    chk("hz_new_data", last_dlv_data, wdat);

    for (int i = 0; i < 9; i++) begin
      acc_v = vt[i].av; acc_a = vt[i].aa; dlv_v = vt[i].dv; dlv_a = vt[i].da;
      wr_en = vt[i].we; wr_a = vt[i].wa; wr_d = {$urandom, $urandom};
      cycle();
      chk($sformatf("vec%0d_gnt", i), DW'(dut_gnt), DW'(vt[i].gnt));
      chk($sformatf("vec%0d_addr", i), DW'(dut_addr), DW'(vt[i].raddr));
    end
    idle(3);

    // Reset one cycle after a grant discards the in-flight read.
    acc_v = 1'b1; acc_a = 6'd1;
    cycle();
    c0 = rsp_cnt;
    rst_n = 1'b0;
    cycle();
    acc_v = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    cycle();
    chk("rst_discard", DW'(rsp_cnt), DW'(c0));
    idle(2);

    // Streaming dlv reads over the whole buffer.
    c0 = rsp_cnt;
    dlv_v = 1'b1;
    for (int a = 0; a < 64; a++) begin dlv_a = AW'(a); cycle(); end
    idle(3);
    chk("stream_count", DW'(rsp_cnt - c0), 64'd64);
    chk("queue_empty", DW'(sbq.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/nv_nvdla_cacc_abuf_arb.md
NV_NVDLA_CACC_ABUF_ARB -- requirements
Module: NV_NVDLA_CACC_abuf_arb

Interface
REQ-001 SHALL have parameter AW, default 6, assembly-buffer address width (depth 2**AW).
REQ-002 SHALL have parameter DW, default 512, assembly-buffer data width.
REQ-003 nvdla_core_clk  in  1  sole clock; all state on rising edge.
REQ-004 nvdla_core_rstn  in  1  reset; asynchronous, active-low.
REQ-005 acc_rd_req_valid / acc_rd_req_ready / acc_rd_req_addr  in/out/in  1/1/AW  accumulate read request.
REQ-006 dlv_rd_req_valid / dlv_rd_req_ready / dlv_rd_req_addr  in/out/in  1/1/AW  delivery read request.
REQ-007 acc_wr_en / acc_wr_addr / acc_wr_data  in  1/AW/DW  accumulate write; never backpressured.
REQ-008 abuf_rd_en / abuf_rd_addr  out  1/AW  buffer read port.
REQ-009 abuf_wr_en / abuf_wr_addr / abuf_wr_data  out  1/AW/DW  buffer write port.
REQ-010 abuf_rd_data  in  DW  buffer read data, valid 2 cycles after abuf_rd_en.
REQ-011 acc_rd_rsp_valid / dlv_rd_rsp_valid  out  1  per-requester response strobe.
REQ-012 rd_rsp_data  out  DW  shared response data.
REQ-013 rd_busy  out  1  any read in the 2-stage return pipe.

Function
REQ-014 Write path SHALL be a pure pass-through: abuf_wr_* = acc_wr_* combinationally, zero latency.
REQ-015 Request accepted when valid && ready; at most one grant per cycle.
REQ-016 Hazard: a requester's ready SHALL be 0 while acc_wr_en=1 and acc_wr_addr equals that requester's addr.
REQ-017 abuf_rd_en SHALL be 1 exactly in cycles with a grant; abuf_rd_addr = granted requester's addr (0 when no grant).
REQ-018 ready SHALL NOT depend on the same requester's valid; a non-granted valid requester keeps its request asserted until granted.
REQ-019 Tag pipe: a 2-stage shift register {valid, id} SHALL carry each grant; the response strobe for that id fires exactly 2 cycles after the grant.
REQ-020 rd_rsp_data SHALL equal abuf_rd_data in the cycle a response strobe is 1; value is don't-care otherwise.
REQ-021 Responses carry no backpressure; a full pipe never stalls; one grant per cycle yields one response per cycle.
REQ-022 rd_busy = OR of both tag-stage valids.
REQ-023 Only one requester valid and no hazard: it SHALL be granted in the same cycle.
REQ-024 Both valid, both hazard-free: the winner is chosen per REQ-030/031.
REQ-025 Both valid, winner blocked by hazard: the other, if hazard-free, SHALL be granted.

Reset
REQ-026 On nvdla_core_rstn low: tag pipe cleared; all response strobes, rd_busy, abuf_rd_en = 0; RR pointer = acc.
REQ-027 Reset mid-operation SHALL discard in-flight reads; no response strobe fires for them after release.
REQ-028 First grant SHALL be possible in the first cycle after reset release.

Configuration
REQ-029 Macro NVDLA_CACC_ABUF_ARB_RR_EN selects the arbitration policy.
REQ-030 Defined: round-robin; 1-bit last-grant pointer updated on each grant; on conflict, the requester not granted last wins.
REQ-031 Undefined: fixed priority acc > dlv; no pointer flop exists.

Structure
REQ-032 Shared package nv_nvdla_cacc_pkg SHALL hold requester-id enum (ACC=0, DLV=1) and the read-latency constant ABUF_RD_LAT=2.
REQ-033 One sub-module NV_NVDLA_CACC_abuf_rdtag (parameterised-depth {valid,id} delay pipe) SHALL be used.

Verification
REQ-034 Single acc read addr 5 at cycle T, no write -> abuf_rd_en/addr=5 at T; acc_rd_rsp_valid at T+2 with data of addr 5.
REQ-035 acc and dlv both valid 4 consecutive cycles (RR_EN) -> grants acc,dlv,acc,dlv; strobes alternate at T+2..T+5.
REQ-036 Same as 035 without RR_EN -> acc granted all 4 cycles, dlv_rd_req_ready=0 throughout.
REQ-037 dlv read addr 9 with acc_wr_en addr 9 same cycle, acc read addr 3 -> acc granted, dlv ready=0; dlv granted next cycle, reads new data.
REQ-038 Grant at T, reset asserted T+1, released T+3 -> no response strobes T+1..T+4; rd_busy=0 after reset.
REQ-039 Back-to-back dlv reads addr 0..63 -> 64 strobes, one per cycle, data order matches address order, rd_busy high throughout.
